seeed_tft_panel_responder: RTL and testbench

SEEED_TFT_PANEL_RESPONDER -- requirements
Module: seeed_tft_panel_responder

---
 rtl/seeed_tft_panel_responder.sv | 147 ++++++++++++++
 tb/tb_seeed_tft_panel_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seeed_tft_panel_responder.sv
// 8080-style TFT panel responder: command/register/pixel capture with an async host bus.
// Every strobe passes through a 2-flop synchronizer; a strobe held over reset must fall before it counts.
module seeed_tft_panel_responder #(
  parameter logic [7:0] ID_VALUE = 8'h93,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_mode,
  input  logic       i_write,
  input  logic       i_read,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_en,
  output logic       o_cmd_stb,
  output logic [7:0] o_cmd,
  output logic       o_pix_stb,
  output logic [7:0] o_pix_data,
  output logic [3:0] o_reg_idx,
  output logic       o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0] state;
  logic       wr_m, wr_s, rd_m, rd_s, rs_m, rs_s;
  logic [7:0] dat_m, dat_s;
  logic [1:0] settle;
  logic       wr_arm, rd_arm;
  logic       wr_p, rd_p;
  logic       cap_rs;
  logic [7:0] cap_dat;
  logic       mem_wr;
  logic [7:0] regs [0:15];

  // Strobes are ignored until seen low after reset so a held strobe cannot fake an edge.
  logic wr_v, rd_v, wr_rise, wr_fall, rd_rise, rd_fall, err_evt;
  logic [7:0] rd_val;

  always_comb begin
    wr_v    = wr_arm & wr_s;
    rd_v    = rd_arm & rd_s;
    wr_rise = wr_v & ~wr_p;
    wr_fall = ~wr_v & wr_p;
    rd_rise = rd_v & ~rd_p;
    rd_fall = ~rd_v & rd_p;
    err_evt = wr_v & rd_v & ~(wr_p & rd_p);
    rd_val  = (o_reg_idx == 4'd0) ? ID_VALUE : regs[o_reg_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_m       <= 1'b0;
      wr_s       <= 1'b0;
      rd_m       <= 1'b0;
      rd_s       <= 1'b0;
      rs_m       <= 1'b0;
      rs_s       <= 1'b0;
      dat_m      <= 8'h00;
      dat_s      <= 8'h00;
      settle     <= 2'd0;
      wr_arm     <= 1'b0;
      rd_arm     <= 1'b0;
      wr_p       <= 1'b0;
      rd_p       <= 1'b0;
      cap_rs     <= 1'b0;
      cap_dat    <= 8'h00;
      mem_wr     <= 1'b0;
      o_data     <= 8'h00;
      o_data_en  <= 1'b0;
      o_cmd_stb  <= 1'b0;
      o_cmd      <= 8'h00;
      o_pix_stb  <= 1'b0;
      o_pix_data <= 8'h00;
      o_reg_idx  <= 4'd0;
      o_err      <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      wr_m  <= i_write;
      wr_s  <= wr_m;
      rd_m  <= i_read;
      rd_s  <= rd_m;
      rs_m  <= i_cmd_mode;
      rs_s  <= rs_m;
      dat_m <= i_data;
      dat_s <= dat_m;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && !wr_s) wr_arm <= 1'b1;
      if (settle == 2'd2 && !rd_s) rd_arm <= 1'b1;
      wr_p <= wr_v;
      rd_p <= rd_v;
      // Last write-high cycle's bus value survives the falling edge.
      if (wr_v) begin
        cap_dat <= dat_s;
        cap_rs  <= rs_s;
      end
      o_cmd_stb <= 1'b0;
      o_pix_stb <= 1'b0;
      o_err     <= 1'b0;

      if (err_evt) begin
        state     <= S_IDLE;
        o_err     <= 1'b1;
        o_data_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (wr_rise && !rd_v)      state <= S_WR;
            else if (rd_rise && !wr_v) state <= S_RD;
          end
          S_WR: begin
            if (wr_fall) begin
              state <= S_IDLE;
              if (!cap_rs) begin
                o_cmd     <= cap_dat;
                o_cmd_stb <= 1'b1;
                if (cap_dat < 8'h10) o_reg_idx <= cap_dat[3:0];
                mem_wr <= (cap_dat == 8'h2C);
              end else if (mem_wr) begin
                o_pix_data <= cap_dat;
                o_pix_stb  <= 1'b1;
              end else begin
                if (o_reg_idx != 4'd0) regs[o_reg_idx] <= cap_dat;
                if (AUTO_INC) o_reg_idx <= o_reg_idx + 4'd1;
              end
            end
          end
          S_RD: begin
            if (rd_fall) begin
              state     <= S_IDLE;
              o_data_en <= 1'b0;
              if (AUTO_INC) o_reg_idx <= o_reg_idx + 4'd1;
            end else begin
              o_data    <= rd_val;
              o_data_en <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seeed_tft_panel_responder.sv
// Directed bench for seeed_tft_panel_responder: host bus transactions with hand-computed results.
module tb_seeed_tft_panel_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cmd_mode, i_write, i_read;
  logic [7:0] i_data;
  logic [7:0] o_data, o_cmd, o_pix_data;
  logic       o_data_en, o_cmd_stb, o_pix_stb, o_err;
  logic [3:0] o_reg_idx;

  int total = 0;
  int bad   = 0;
  int cmd_cnt = 0, pix_cnt = 0, err_cnt = 0, en_cnt = 0;
  logic [7:0] pix_log [0:15];
  int c0, p0, e0, n0;

  seeed_tft_panel_responder dut (
    .clk(clk), .rst(rst), .i_cmd_mode(i_cmd_mode), .i_write(i_write), .i_read(i_read),
    .i_data(i_data), .o_data(o_data), .o_data_en(o_data_en), .o_cmd_stb(o_cmd_stb),
    .o_cmd(o_cmd), .o_pix_stb(o_pix_stb), .o_pix_data(o_pix_data), .o_reg_idx(o_reg_idx),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Every high cycle is counted, so a strobe stuck high shows up as extra events.
  always @(negedge clk) begin
    if (o_cmd_stb) cmd_cnt <= cmd_cnt + 1;
    if (o_err)     err_cnt <= err_cnt + 1;
    if (o_data_en) en_cnt  <= en_cnt + 1;
    if (o_pix_stb) begin
      pix_log[pix_cnt[3:0]] <= o_pix_data;
      pix_cnt <= pix_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic rs, input logic [7:0] b);
    @(negedge clk);
    i_cmd_mode = rs;
    i_data     = b;
    i_write    = 1'b1;
    repeat (6) @(negedge clk);
    i_write = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic host_rd(input string tag, input logic [7:0] exp);
    @(negedge clk);
    i_read = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_en"}, {31'd0, o_data_en}, 32'd1);
    chk({tag, "_dat"}, {24'd0, o_data}, {24'd0, exp});
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, {31'd0, o_data_en}, 32'd1);
    i_read = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_drop"}, {31'd0, o_data_en}, 32'd0);
    chk({tag, "_keep"}, {24'd0, o_data}, {24'd0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_cmd_mode = 1'b0; i_write = 1'b0; i_read = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data",  {24'd0, o_data}, 32'h0);
    chk("rst_en",    {31'd0, o_data_en}, 32'd0);
    chk("rst_cmd",   {24'd0, o_cmd}, 32'h0);
    chk("rst_idx",   {28'd0, o_reg_idx}, 32'd0);
    chk("rst_pix",   {24'd0, o_pix_data}, 32'h0);
    chk("rst_strb",  {29'd0, o_cmd_stb, o_pix_stb, o_err}, 32'd0);

    // Register write through command-selected index
    host_wr(1'b0, 8'h05);
    host_wr(1'b1, 8'hA7);
    chk("c05_cnt", cmd_cnt, 1);
    chk("c05_cmd", {24'd0, o_cmd}, 32'h05);
    chk("c05_idx", {28'd0, o_reg_idx}, 32'd6);
    host_wr(1'b0, 8'h05);
    host_rd("rd5", 8'hA7);
    chk("rd5_idx", {28'd0, o_reg_idx}, 32'd6);

    // ID register
    host_wr(1'b0, 8'h00);
    host_rd("rdid", 8'h93);
    chk("rdid_idx", {28'd0, o_reg_idx}, 32'd1);

    // Memory-write mode
    p0 = pix_cnt;
    host_wr(1'b0, 8'h2C);
    host_wr(1'b1, 8'h11);
    host_wr(1'b1, 8'h22);
    host_wr(1'b1, 8'h33);
    chk("pix_cnt", pix_cnt - p0, 3);
    chk("pix0", {24'd0, pix_log[p0]},     32'h11);
    chk("pix1", {24'd0, pix_log[p0 + 1]}, 32'h22);
    chk("pix2", {24'd0, pix_log[p0 + 2]}, 32'h33);
    chk("pix_idx", {28'd0, o_reg_idx}, 32'd1);
    host_wr(1'b0, 8'h01);
    host_wr(1'b1, 8'h77);
    chk("mode_clr", pix_cnt - p0, 3);
    chk("mode_idx", {28'd0, o_reg_idx}, 32'd2);
    host_wr(1'b0, 8'h05);
    host_rd("rd5b", 8'hA7);
    host_wr(1'b0, 8'h01);
    host_rd("rd1", 8'h77);

    // Index wrap
    host_wr(1'b0, 8'h0F);
    host_wr(1'b1, 8'h5A);
    chk("wrap_idx", {28'd0, o_reg_idx}, 32'd0);
    host_rd("wrap_id", 8'h93);
    host_wr(1'b0, 8'h0F);
    host_rd("rd15", 8'h5A);
    chk("rd15_idx", {28'd0, o_reg_idx}, 32'd0);

    // Index 0 writes are ignored but still advance
    host_wr(1'b1, 8'hEE);
    chk("w0_idx", {28'd0, o_reg_idx}, 32'd1);
    host_wr(1'b0, 8'h00);
    host_rd("w0_id", 8'h93);

    // Simultaneous strobes
    c0 = cmd_cnt; e0 = err_cnt; n0 = en_cnt;
    @(negedge clk);
    i_cmd_mode = 1'b0; i_data = 8'h09; i_write = 1'b1; i_read = 1'b1;
    repeat (6) @(negedge clk);
    i_write = 1'b0; i_read = 1'b0;
    repeat (8) @(negedge clk);
    chk("err_cnt", err_cnt - e0, 1);
    chk("err_nocap", cmd_cnt - c0, 0);
    chk("err_noen", en_cnt - n0, 0);
    chk("err_idx", {28'd0, o_reg_idx}, 32'd1);

    // Reset during a held write
    c0 = cmd_cnt;
    @(negedge clk);
    i_cmd_mode = 1'b0; i_data = 8'hFF; i_write = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    i_write = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstw_cnt", cmd_cnt - c0, 0);
    chk("rstw_cmd", {24'd0, o_cmd}, 32'h0);
    chk("rstw_idx", {28'd0, o_reg_idx}, 32'd0);
    host_wr(1'b0, 8'h03);
    chk("post_cnt", cmd_cnt - c0, 1);
    chk("post_idx", {28'd0, o_reg_idx}, 32'd3);
    host_wr(1'b0, 8'h05);
    host_rd("post_rd5", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
